// File: rtl/ws_col_requant_if.sv
// Valid/ready stream bundle with a last sideband; W sets the payload width.
interface ws_col_requant_if #(
  parameter int W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/ws_col_requant.sv
// Per-column requantization stage: bias add, TFLM fixed-point rescale,
// zero-point add and clamp, in a 3-stage pipeline stalled as a whole.
module ws_col_requant #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ws_col_requant_if.slave             in_st,
  ws_col_requant_if.master            out_st,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic signed [ACC_WIDTH-1:0] cfg_bias,
  input  logic signed [ACC_WIDTH-1:0] cfg_mult,
  input  logic signed [5:0]           cfg_shift,
  input  logic signed [OUT_WIDTH-1:0] cfg_zp,
  input  logic signed [OUT_WIDTH-1:0] cfg_act_min,
  input  logic signed [OUT_WIDTH-1:0] cfg_act_max,
  output logic [15:0]                 out_count
);

  logic signed [ACC_WIDTH-1:0] bias_q, mult_q;
  logic signed [5:0]           shift_q;
  logic signed [OUT_WIDTH-1:0] zp_q, min_q, max_q;

  logic                        v1, v2, ov;
  logic signed [ACC_WIDTH-1:0] s1_acc, s2_hi;
  logic                        s1_last, s2_last, ol;
  logic signed [OUT_WIDTH-1:0] od;
  logic [15:0]                 cnt;
  logic                        clr_pend;

  logic advance, in_hs, out_hs;

  function automatic logic signed [31:0] sat32(input logic signed [63:0] x);
    logic signed [63:0] hi_lim, lo_lim;
    hi_lim = 64'sh0000_0000_7FFF_FFFF;
    lo_lim = 64'shFFFF_FFFF_8000_0000;
    if (x > hi_lim)      sat32 = 32'sh7FFF_FFFF;
    else if (x < lo_lim) sat32 = 32'sh8000_0000;
    else                 sat32 = x[31:0];
  endfunction

  function automatic logic signed [31:0] stage1(input logic signed [31:0] s,
                                                input logic signed [31:0] b,
                                                input logic signed [5:0]  sh);
    logic signed [63:0] t;
    logic signed [31:0] a;
    t = 64'(s) + 64'(b);
    a = sat32(t);
    if (sh > 6'sd0) begin
      t = 64'(a) <<< sh[4:0];
      a = sat32(t);
    end
    stage1 = a;
  endfunction

  // Saturating rounding doubling high multiply; the truncation toward zero is
  // done as an arithmetic shift plus a correction for negative inexact values.
  function automatic logic signed [31:0] srdhm(input logic signed [31:0] a,
                                               input logic signed [31:0] m);
    logic signed [63:0] p, q;
    if (a == 32'sh8000_0000 && m == 32'sh8000_0000) begin
      srdhm = 32'sh7FFF_FFFF;
    end else begin
      p = 64'(a) * 64'(m);
      p = p + (p[63] ? 64'shFFFF_FFFF_C000_0001 : 64'sh0000_0000_4000_0000);
      q = p >>> 31;
      if (p[63] && (p[30:0] != '0)) q = q + 64'sd1;
      srdhm = q[31:0];
    end
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] stage3(
      input logic signed [31:0]          hi,
      input logic signed [5:0]           sh,
      input logic signed [OUT_WIDTH-1:0] zp,
      input logic signed [OUT_WIDTH-1:0] mn,
      input logic signed [OUT_WIDTH-1:0] mx);
    logic signed [5:0]  nsh;
    logic [4:0]         e;
    logic [31:0]        mask, rem, thr;
    logic signed [31:0] r;
    logic signed [32:0] v;
    r = hi;
    if (sh < 6'sd0) begin
      nsh  = -sh;
      e    = nsh[4:0];
      mask = (32'd1 << e) - 32'd1;
      rem  = hi & mask;
      thr  = (mask >> 1) + {31'd0, hi[31]};
      r    = (hi >>> e) + ((rem > thr) ? 32'sd1 : 32'sd0);
    end
    v = 33'(r) + 33'(zp);
    if (v < 33'(mn))      v = 33'(mn);
    else if (v > 33'(mx)) v = 33'(mx);
    stage3 = v[OUT_WIDTH-1:0];
  endfunction

  assign advance      = !ov || out_st.ready;
  assign in_hs        = in_st.valid && advance;
  assign out_hs       = ov && out_st.ready;
  assign in_st.ready  = advance;
  assign cfg_ready    = !(v1 || v2 || ov) && !in_hs;
  assign out_st.valid = ov;
  assign out_st.data  = od;
  assign out_st.last  = ol;
  assign out_count    = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_q   <= '0;
      mult_q   <= 32'sh4000_0000;
      shift_q  <= '0;
      zp_q     <= '0;
      min_q    <= {1'b1, {(OUT_WIDTH-1){1'b0}}};
      max_q    <= {1'b0, {(OUT_WIDTH-1){1'b1}}};
      v1       <= 1'b0;
      v2       <= 1'b0;
      ov       <= 1'b0;
      s1_acc   <= '0;
      s1_last  <= 1'b0;
      s2_hi    <= '0;
      s2_last  <= 1'b0;
      od       <= '0;
      ol       <= 1'b0;
      cnt      <= '0;
      clr_pend <= 1'b0;
    end else begin
      if (cfg_valid && cfg_ready) begin
        bias_q  <= cfg_bias;
        mult_q  <= cfg_mult;
        shift_q <= cfg_shift;
        zp_q    <= cfg_zp;
        min_q   <= cfg_act_min;
        max_q   <= cfg_act_max;
      end

      // Whole pipeline moves together; empty slots travel as bubbles.
      if (advance) begin
        v1 <= in_hs;
        if (in_hs) begin
          s1_acc  <= stage1($signed(in_st.data), bias_q, shift_q);
          s1_last <= in_st.last;
        end
        v2 <= v1;
        if (v1) begin
          s2_hi   <= srdhm(s1_acc, mult_q);
          s2_last <= s1_last;
        end
        ov <= v2;
        if (v2) begin
          od <= stage3(s2_hi, shift_q, zp_q, min_q, max_q);
          ol <= s2_last;
        end
      end

      // The tile-ending element is shown in the count for one cycle before clearing.
      if (clr_pend)    cnt <= out_hs ? 16'd1 : 16'd0;
      else if (out_hs) cnt <= cnt + 16'd1;
      clr_pend <= out_hs && ol;
    end
  end

endmodule

// File: tb/tb_ws_col_requant.sv
// Randomized bench for ws_col_requant against an arithmetic reference model.
module tb_ws_col_requant;

  logic              clk;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic signed [31:0] cfg_bias, cfg_mult;
  logic signed [5:0]  cfg_shift;
  logic signed [7:0]  cfg_zp, cfg_act_min, cfg_act_max;
  logic [15:0]       out_count;

  ws_col_requant_if #(.W(32)) in_if ();
  ws_col_requant_if #(.W(8))  out_if ();

  ws_col_requant #(.ACC_WIDTH(32), .OUT_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_st      (in_if),
    .out_st     (out_if),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_bias   (cfg_bias),
    .cfg_mult   (cfg_mult),
    .cfg_shift  (cfg_shift),
    .cfg_zp     (cfg_zp),
    .cfg_act_min(cfg_act_min),
    .cfg_act_max(cfg_act_max),
    .out_count  (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint clip(input longint x, input longint lo, input longint hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  // Reference: exact integer arithmetic; final divide is round-half-away-from-zero.
  function automatic int ref_req(input int s, input int b, input int m, input int sh,
                                 input int zp, input int mn, input int mx);
    longint lo, hl, acc, p, hi, r, half;
    lo  = -(longint'(1) << 31);
    hl  = (longint'(1) << 31) - 1;
    acc = clip(longint'(s) + longint'(b), lo, hl);
    if (sh > 0) acc = clip(acc * (longint'(1) << sh), lo, hl);
    if (acc == lo && longint'(m) == lo) begin
      hi = hl;
    end else begin
      p  = acc * longint'(m);
      hi = (p + ((p >= 0) ? (longint'(1) << 30) : (1 - (longint'(1) << 30)))) / (longint'(1) << 31);
    end
    if (sh < 0) begin
      half = longint'(1) << (-sh - 1);
      if (hi >= 0) r = (hi + half) >> (-sh);
      else         r = -((-hi + half) >> (-sh));
    end else begin
      r = hi;
    end
    return int'(clip(r + longint'(zp), longint'(mn), longint'(mx)));
  endfunction

  typedef struct {
    int d;
    bit l;
    bit hl;
    int lit;
    int t;
    bit lat;
  } ent_t;

  ent_t sb[$];
  int   m_b, m_m, m_sh, m_zp, m_mn, m_mx;
  int   cyc = 0;
  int   rmode = 0;
  bit   cur_hl;
  int   cur_lit;
  int   exp_cnt;
  bit   clr_pend, prev_stall, prev_l;
  int   prev_d;
  bit   in_hs, out_hs, exp_cfg_rdy;
  ent_t e;

  always @(posedge clk) cyc++;

  // out_ready driver: 0 = held high, 1 = 1-0-0-1 pattern, 2 = random, 3 = held low
  initial begin
    int ph;
    ph = 0;
    out_if.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: out_if.ready = 1'b1;
        1: begin out_if.ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
        2: out_if.ready = 1'($urandom_range(1));
        default: out_if.ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_cnt = 0; clr_pend = 0; prev_stall = 0;
      m_b = 0; m_m = 32'h4000_0000; m_sh = 0; m_zp = 0; m_mn = -128; m_mx = 127;
    end else begin
      in_hs  = in_if.valid && in_if.ready;
      out_hs = out_if.valid && out_if.ready;
      exp_cfg_rdy = (sb.size() == 0) && !in_hs;
      chk("cfg_ready", cfg_ready, exp_cfg_rdy);
      chk("in_ready", in_if.ready, !out_if.valid || out_if.ready);
      chk("out_count", out_count, exp_cnt);
      if (prev_stall) begin
        chk("hold_valid", out_if.valid, 1);
        chk("hold_data", $signed(out_if.data), prev_d);
        chk("hold_last", out_if.last, prev_l);
      end
      if (cfg_valid && exp_cfg_rdy) begin
        m_b = cfg_bias; m_m = cfg_mult; m_sh = cfg_shift;
        m_zp = cfg_zp; m_mn = cfg_act_min; m_mx = cfg_act_max;
      end
      if (in_hs) begin
        e.d   = ref_req($signed(in_if.data), m_b, m_m, m_sh, m_zp, m_mn, m_mx);
        e.l   = in_if.last;
        e.hl  = cur_hl;
        e.lit = cur_lit;
        e.t   = cyc;
        e.lat = (rmode == 0);
        sb.push_back(e);
      end
      if (clr_pend) begin
        exp_cnt = out_hs ? 1 : 0;
        clr_pend = 0;
      end else if (out_hs) begin
        exp_cnt = (exp_cnt + 1) % 65536;
      end
      if (out_hs) begin
        if (sb.size() == 0) begin
          chk("extra_out", out_if.valid, 0);
        end else begin
          e = sb.pop_front();
          chk("data", $signed(out_if.data), e.d);
          chk("last", out_if.last, e.l);
          if (e.hl) chk("lit", $signed(out_if.data), e.lit);
          if (e.lat && rmode == 0) chk("latency", cyc - e.t, 3);
          clr_pend = e.l;
        end
      end
      prev_stall = out_if.valid && !out_if.ready;
      prev_d     = $signed(out_if.data);
      prev_l     = out_if.last;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int s, input bit l, input bit hl, input int lit);
    bit ok;
    ok = 0;
    cur_hl = hl; cur_lit = lit;
    in_if.valid = 1'b1; in_if.data = s; in_if.last = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_if.ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", ok, 1);
    tick();
    in_if.valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1; break; end
    end
    chk("drain", ok, 1);
    tick();
  endtask

  task automatic do_cfg(input int b, input int m, input int sh, input int zp,
                        input int mn, input int mx);
    cfg_bias = b; cfg_mult = m; cfg_shift = sh[5:0];
    cfg_zp = zp[7:0]; cfg_act_min = mn[7:0]; cfg_act_max = mx[7:0];
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  function automatic int rnd_sum();
    case ($urandom_range(3))
      0: return int'($urandom);
      1: return int'($urandom_range(4000)) - 2000;
      2: return $urandom_range(1) ? int'(32'h8000_0000) : int'(32'h7FFF_FFFF);
      default: return int'($urandom_range(200000)) - 100000;
    endcase
  endfunction

  initial begin
    int a, c, n;
    rst_n = 1'b0;
    in_if.valid = 1'b0; in_if.data = '0; in_if.last = 1'b0;
    cfg_valid = 1'b0; cfg_bias = '0; cfg_mult = '0; cfg_shift = '0;
    cfg_zp = '0; cfg_act_min = '0; cfg_act_max = '0;
    cur_hl = 0; cur_lit = 0;
    #2;
    chk("rst_in_ready", in_if.ready, 1);
    chk("rst_out_valid", out_if.valid, 0);
    chk("rst_out_data", out_if.data, 0);
    chk("rst_out_last", out_if.last, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_out_count", out_count, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // defaults after reset: unity-ish rescale (hi = acc/2)
    send(100, 1, 1, 50);
    drain();

    // default flow
    do_cfg(24, 32'h4000_0000, -2, -128, -128, 127);
    send(1000, 1, 1, 0);
    drain();

    // saturation
    do_cfg(1000, 32'h7FFF_FFFF, 0, 0, -128, 127);
    send(2147483000, 0, 1, 127);
    drain();
    do_cfg(-1000, 32'h7FFF_FFFF, 0, 0, -128, 127);
    send(-2147483000, 1, 1, -128);
    drain();

    // rounding ties away from zero
    do_cfg(0, 32'h4000_0000, -1, 0, -128, 127);
    send(-6, 0, 1, -2);
    send(6, 0, 1, 2);
    send(5, 1, 1, 2);
    drain();

    // SRDHM overflow corner
    do_cfg(0, int'(32'h8000_0000), 0, 0, -128, 127);
    send(int'(32'h8000_0000), 1, 1, 127);
    drain();

    // backpressure with 1-0-0-1 out_ready
    do_cfg(24, 32'h4000_0000, -2, -128, -128, 127);
    rmode = 1;
    for (int i = 0; i < 8; i++) send(i * 300 - 1000, i == 7, 0, 0);
    drain();
    rmode = 0;
    tick(); tick();

    // config guard: ignored while busy, takes effect after drain
    rmode = 3;
    send(1000, 0, 1, 0);
    send(2000, 1, 1, 125);
    repeat (4) tick();
    do_cfg(0, 32'h4000_0000, 0, 0, -128, 127);
    rmode = 0;
    drain();
    do_cfg(0, 32'h4000_0000, 0, 0, -128, 127);
    send(100, 1, 1, 50);
    drain();

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      rmode = r % 3;
      a = int'($urandom_range(255)) - 128;
      c = int'($urandom_range(255)) - 128;
      do_cfg($urandom_range(1) ? int'($urandom) : int'($urandom_range(2000)) - 1000,
             ($urandom_range(3) == 0) ? int'(32'h8000_0000) : int'($urandom),
             int'($urandom_range(61)) - 31,
             int'($urandom_range(255)) - 128,
             (a < c) ? a : c, (a < c) ? c : a);
      n = 30;
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(2)) tick();
        send(rnd_sum(), (i == n - 1) || ($urandom_range(7) == 0), 0, 0);
      end
      drain();
    end
    rmode = 0;
    tick(); tick();

    // asynchronous reset with elements in flight
    rmode = 3;
    send(rnd_sum(), 0, 0, 0);
    send(rnd_sum(), 0, 0, 0);
    send(rnd_sum(), 0, 0, 0);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_if.valid, 0);
    chk("arst_out_data", out_if.data, 0);
    chk("arst_out_last", out_if.last, 0);
    chk("arst_out_count", out_count, 0);
    chk("arst_cfg_ready", cfg_ready, 1);
    chk("arst_in_ready", in_if.ready, 1);
    rmode = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send(100, 1, 1, 50);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws_col_requant.md
# ws_col_requant

Per-column output stage of the weight-stationary systolic array. It consumes the saturated ACC_WIDTH partial sums leaving the bottom cell of one column and adds a per-column bias. It requantizes the result with TFLM integer arithmetic (fixed-point multiplier plus power-of-two shift), adds the output zero point, clamps to the activation range, and delivers OUT_WIDTH results over a valid/ready handshake. The datapath is a 3-stage pipeline stalled as a whole by backpressure; quantization parameters are loaded through a config port only while the pipeline is empty.

## Interface
- ACC_WIDTH, 32, width of sum_in, bias and internal accumulator (fixed 32 for TFLM semantics)
- OUT_WIDTH, 8, signed output width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sum_in/in_last valid
- in_ready  out  1  stage accepts input this cycle
- sum_in  in  ACC_WIDTH  signed column partial sum
- in_last  in  1  marks final element of a tile
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  OUT_WIDTH  signed requantized result
- out_last  out  1  in_last carried with the element
- cfg_valid  in  1  load quantization parameters
- cfg_ready  out  1  high when pipeline empty (no stage valid)
- cfg_bias  in  32  signed bias
- cfg_mult  in  32  signed Q31 multiplier
- cfg_shift  in  6  signed shift, range -31..+30
- cfg_zp  in  OUT_WIDTH  signed output zero point
- cfg_act_min, cfg_act_max  in  OUT_WIDTH  signed clamp bounds, min <= max
- out_count  out  16  elements delivered since reset/last out_last handshake

## Operation
- Config registers load on cfg_valid && cfg_ready; cfg_valid while cfg_ready=0 is ignored (no queuing).
- S1: acc = sat32(sum_in + bias); if shift > 0, acc = sat32(acc << shift).
- S2: SRDHM: if acc == -2^31 and mult == -2^31 -> 2^31-1; else p = acc*mult (64-bit), nudge = p>=0 ? 2^30 : 1-2^30, hi = (p+nudge)/2^31 truncated toward zero.
- S3: if shift < 0, e = -shift, mask = 2^e-1, rem = hi & mask, thr = (mask>>1) + (hi<0), r = (hi >>> e) + (rem > thr); else r = hi. Then v = r + zp (33-bit), out = clamp(v, act_min, act_max).
- Sideband in_last travels with its element through all stages.
- out_count increments on each out handshake; resets to 0 on the cycle after an out_last handshake (that handshake still counts before clearing).

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, out_last 0, cfg_ready 1, out_count 0; stage valids 0; cfg regs bias 0, mult 0x40000000, shift 0, zp 0, act_min -2^(OUT_WIDTH-1), act_max 2^(OUT_WIDTH-1)-1.
- advance = !out_valid || out_ready; in_ready = advance (combinational, no in_valid dependency).
- On advance all stages shift by one; bubbles are not collapsed. Latency in->out_valid = 3 cycles with no stall.
- Throughput 1/cycle while out_ready held high.
- out_valid held with stable out_data/out_last until out_ready; no drop, no duplication.
- cfg_ready = no stage valid and no in handshake this cycle; a cfg load and an in handshake never coincide.
- Reset mid-operation: all in-flight elements discarded, outputs return to reset values asynchronously; config returns to defaults.

## Test plan
- Default flow: cfg bias 24, mult 0x40000000, shift -2, zp -128; sum_in 1000 -> out_data 0 exactly 3 cycles after handshake.
- Saturation: bias 1000, mult 0x7FFFFFFF, shift 0, zp 0; sum_in 2147483000 -> 127; sum_in -2147483000, bias -1000 -> -128.
- Rounding: mult 0x40000000, shift -1, zp 0; sum_in -6 -> -2; sum_in 6 -> 2; sum_in 5 (hi 3 -> 1.5) -> 2.
- Corner: bias 0, sum_in -2^31, mult 0x80000000, shift 0 -> SRDHM 2^31-1 -> out 127.
- Backpressure: stream 8 values with in_last on 8th, out_ready toggled 1-0-0-1 pattern -> all 8 in order, no loss, out_last on 8th, out_count 1..8 then 0.
- Config guard: cfg_valid while 2 elements in flight -> ignored (cfg_ready 0), old params used; reapplied after drain -> takes effect on next element.
